// File: rtl/core_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle memory sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    RETIRE,
    TRAP
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned INSTRET_W = 64;

endpackage

// File: rtl/core_seq_watchdog.sv
// Memory-phase timeout counter; flags the cycle on which a phase has lasted TIMEOUT_CYCLES.
module core_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Every REQ state is entered from a non-counting state, so idling clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!count_en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = count_en && (cnt == LAST);

endmodule

// File: rtl/core_mem_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer with valid/ready memory handshakes.
// Optional memory timeout trap enabled by defining CORE_SEQ_TIMEOUT_EN.
module core_mem_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef CORE_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      i_pc,
  output logic                 o_im_req_valid,
  input  logic                 i_im_req_ready,
  output logic [XLEN-1:0]      o_im_addr,
  input  logic                 i_im_rsp_valid,
  input  logic [XLEN-1:0]      i_im_rsp_data,
  output logic [XLEN-1:0]      o_instr,
  input  logic                 i_cu_dm_access,
  input  logic                 i_cu_dm_write,
  input  logic                 i_cu_rf_wvalid,
  output logic                 o_dm_req_valid,
  output logic                 o_dm_req_write,
  input  logic                 i_dm_req_ready,
  input  logic                 i_dm_rsp_valid,
  input  logic [XLEN-1:0]      i_dm_rsp_data,
  output logic [XLEN-1:0]      o_dm_rdata,
  output logic                 o_pc_update,
  output logic                 o_rf_wen,
  output logic [INSTRET_W-1:0] o_instret,
  output logic                 o_trap
);

  state_e state;

  assign o_im_addr = i_pc;

`ifdef CORE_SEQ_TIMEOUT_EN
  logic count_en_c;
  logic timeout_c;

  assign count_en_c = state inside {FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT};

  core_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en_c),
    .expired_c (timeout_c)
  );
`else
  assign o_trap = 1'b0;
`endif

  // Request valids are raised on the edge entering a REQ state and dropped on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH_REQ;
      o_im_req_valid <= 1'b0;
      o_dm_req_valid <= 1'b0;
      o_dm_req_write <= 1'b0;
      o_pc_update    <= 1'b0;
      o_rf_wen       <= 1'b0;
      o_instr        <= XLEN'(NOP_INSTR);
      o_dm_rdata     <= '0;
      o_instret      <= '0;
`ifdef CORE_SEQ_TIMEOUT_EN
      o_trap         <= 1'b0;
`endif
    end else begin
      o_pc_update <= 1'b0;
      o_rf_wen    <= 1'b0;
      case (state)
        FETCH_REQ: begin
          if (o_im_req_valid && i_im_req_ready) begin
            o_im_req_valid <= 1'b0;
            state          <= FETCH_WAIT;
          end else begin
            o_im_req_valid <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (i_im_rsp_valid) begin
            o_instr <= i_im_rsp_data;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (i_cu_dm_access) begin
            o_dm_req_valid <= 1'b1;
            o_dm_req_write <= i_cu_dm_write;
            state          <= MEM_REQ;
          end else begin
            o_pc_update <= 1'b1;
            o_rf_wen    <= i_cu_rf_wvalid;
            state       <= RETIRE;
          end
        end
        MEM_REQ: begin
          if (i_dm_req_ready) begin
            o_dm_req_valid <= 1'b0;
            state          <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (i_dm_rsp_valid) begin
            if (!o_dm_req_write) begin
              o_dm_rdata <= i_dm_rsp_data;
            end
            o_pc_update <= 1'b1;
            o_rf_wen    <= i_cu_rf_wvalid;
            state       <= RETIRE;
          end
        end
        RETIRE: begin
          o_instret      <= o_instret + INSTRET_W'(1);
          o_im_req_valid <= 1'b1;
          state          <= FETCH_REQ;
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH_REQ;
      endcase
`ifdef CORE_SEQ_TIMEOUT_EN
      // A stalled phase overrides any transition and parks the core until reset.
      if (timeout_c) begin
        state          <= TRAP;
        o_trap         <= 1'b1;
        o_im_req_valid <= 1'b0;
        o_dm_req_valid <= 1'b0;
        o_pc_update    <= 1'b0;
        o_rf_wen       <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Scoreboard bench for core_mem_sequencer: a memory model drives handshakes, retires are checked.
module tb_core_mem_sequencer;

  typedef struct packed {
    logic        wen;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        o_im_req_valid;
  logic        i_im_req_ready;
  logic [31:0] o_im_addr;
  logic        i_im_rsp_valid;
  logic [31:0] i_im_rsp_data;
  logic [31:0] o_instr;
  logic        i_cu_dm_access;
  logic        i_cu_dm_write;
  logic        i_cu_rf_wvalid;
  logic        o_dm_req_valid;
  logic        o_dm_req_write;
  logic        i_dm_req_ready;
  logic        i_dm_rsp_valid;
  logic [31:0] i_dm_rsp_data;
  logic [31:0] o_dm_rdata;
  logic        o_pc_update;
  logic        o_rf_wen;
  logic [63:0] o_instret;
  logic        o_trap;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        sb_q[$];
  logic [31:0] exp_rdata;
  logic [63:0] exp_ret;

  core_mem_sequencer #(
    .XLEN (32)
`ifdef CORE_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pc           (pc),
    .o_im_req_valid (o_im_req_valid),
    .i_im_req_ready (i_im_req_ready),
    .o_im_addr      (o_im_addr),
    .i_im_rsp_valid (i_im_rsp_valid),
    .i_im_rsp_data  (i_im_rsp_data),
    .o_instr        (o_instr),
    .i_cu_dm_access (i_cu_dm_access),
    .i_cu_dm_write  (i_cu_dm_write),
    .i_cu_rf_wvalid (i_cu_rf_wvalid),
    .o_dm_req_valid (o_dm_req_valid),
    .o_dm_req_write (o_dm_req_write),
    .i_dm_req_ready (i_dm_req_ready),
    .i_dm_rsp_valid (i_dm_rsp_valid),
    .i_dm_rsp_data  (i_dm_rsp_data),
    .o_dm_rdata     (o_dm_rdata),
    .o_pc_update    (o_pc_update),
    .o_rf_wen       (o_rf_wen),
    .o_instret      (o_instret),
    .o_trap         (o_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) exp_ret = '0;
  end

  // Retire monitor: each PC-advance pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rf_wen_gated", 64'(o_rf_wen & ~o_pc_update), 64'd0);
      if (o_pc_update) begin
        check_eq("retire_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("rf_wen", 64'(o_rf_wen), 64'(e.wen));
          check_eq("dm_rdata", 64'(o_dm_rdata), 64'(e.rdata));
          check_eq("instret_at_retire", o_instret, exp_ret);
        end
        exp_ret = exp_ret + 64'd1;
      end
    end
  end

  task automatic wait_im_valid();
    int n;
    n = 0;
    while (!o_im_req_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_eq("im_req_valid", 64'(o_im_req_valid), 64'd1);
  endtask

  // Plays fetch unit, control unit and both memories for one instruction.
  task automatic run_instr(input logic [31:0] ins, input logic acc, input logic wr,
                           input logic wv, input int im_wait, input int dm_wait,
                           input int rsp_wait, input logic [31:0] ld, input logic spur,
                           output int cycles);
    wait_im_valid();
    check_eq("im_addr", 64'(o_im_addr), 64'(pc));
    cycles = 0;
    repeat (im_wait) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("im_valid_held", 64'(o_im_req_valid), 64'd1);
    i_im_req_ready = 1'b1;
    @(negedge clk);
    cycles++;
    i_im_req_ready = 1'b0;
    i_im_rsp_valid = 1'b1;
    i_im_rsp_data  = ins;
    @(negedge clk);
    cycles++;
    i_im_rsp_valid = 1'b0;
    i_im_rsp_data  = '0;
    check_eq("instr", 64'(o_instr), 64'(ins));
    i_cu_dm_access = acc;
    i_cu_dm_write  = wr;
    i_cu_rf_wvalid = wv;
    if (spur) begin
      i_im_rsp_valid = 1'b1;
      i_im_rsp_data  = 32'hFFFF_FFFF;
    end
    if (acc) begin
      @(negedge clk);
      cycles++;
      i_im_rsp_valid = 1'b0;
      if (spur) check_eq("instr_spurious", 64'(o_instr), 64'(ins));
      repeat (dm_wait) begin
        check_eq("dm_valid_held", 64'(o_dm_req_valid), 64'd1);
        check_eq("dm_write", 64'(o_dm_req_write), 64'(wr));
        @(negedge clk);
        cycles++;
      end
      check_eq("dm_valid", 64'(o_dm_req_valid), 64'd1);
      check_eq("dm_write", 64'(o_dm_req_write), 64'(wr));
      i_dm_req_ready = 1'b1;
      @(negedge clk);
      cycles++;
      i_dm_req_ready = 1'b0;
      check_eq("dm_valid_dropped", 64'(o_dm_req_valid), 64'd0);
      repeat (rsp_wait) begin
        @(negedge clk);
        cycles++;
      end
      if (!wr) exp_rdata = ld;
      sb_q.push_back('{wen: wv, rdata: exp_rdata});
      i_dm_rsp_valid = 1'b1;
      i_dm_rsp_data  = ld;
      @(negedge clk);
      cycles++;
      i_dm_rsp_valid = 1'b0;
    end else begin
      sb_q.push_back('{wen: wv, rdata: exp_rdata});
      @(negedge clk);
      cycles++;
      i_im_rsp_valid = 1'b0;
      if (spur) check_eq("instr_spurious", 64'(o_instr), 64'(ins));
    end
    @(negedge clk);
    cycles++;
    pc = pc + 32'd4;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    pc = '0;
    i_im_req_ready = 1'b0;
    i_im_rsp_valid = 1'b0;
    i_im_rsp_data  = '0;
    i_cu_dm_access = 1'b0;
    i_cu_dm_write  = 1'b0;
    i_cu_rf_wvalid = 1'b0;
    i_dm_req_ready = 1'b0;
    i_dm_rsp_valid = 1'b0;
    i_dm_rsp_data  = '0;
    exp_rdata = '0;
    exp_ret   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_im_valid", 64'(o_im_req_valid), 64'd0);
    check_eq("rst_dm_valid", 64'(o_dm_req_valid), 64'd0);
    check_eq("rst_instr", 64'(o_instr), 64'h13);
    check_eq("rst_rdata", 64'(o_dm_rdata), 64'd0);
    check_eq("rst_instret", o_instret, 64'd0);
    check_eq("rst_pc_update", 64'(o_pc_update), 64'd0);
    check_eq("rst_rf_wen", 64'(o_rf_wen), 64'd0);
    check_eq("rst_trap", 64'(o_trap), 64'd0);
    rst = 1'b0;

    // ADDI, zero-wait memory
    run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, 0, 32'h0, 1'b0, cyc);
    check_eq("alu_latency", 64'(cyc), 64'd4);
    check_eq("instret_after_addi", o_instret, 64'd1);

    // LW, dm ready after 3 cycles, response 2 cycles after accept
    run_instr(32'h1000_2083, 1'b1, 1'b0, 1'b1, 0, 3, 2, 32'hDEAD_BEEF, 1'b0, cyc);
    check_eq("lw_rdata_held", 64'(o_dm_rdata), 64'hDEAD_BEEF);

    // SW: waits for ack, no rd write, load data register untouched
    run_instr(32'h0020_a023, 1'b1, 1'b1, 1'b0, 1, 0, 1, 32'h1234_5678, 1'b0, cyc);
    check_eq("sw_rdata_kept", 64'(o_dm_rdata), 64'hDEAD_BEEF);

    // zero-wait LW latency
    run_instr(32'h0040_2103, 1'b1, 1'b0, 1'b1, 0, 0, 0, 32'hA5A5_0001, 1'b0, cyc);
    check_eq("ld_latency", 64'(cyc), 64'd6);

    // spurious fetch responses in EXEC for both instruction classes
    run_instr(32'h0000_0063, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b1, cyc);
    run_instr(32'h0080_2183, 1'b1, 1'b0, 1'b1, 0, 1, 0, 32'h0BAD_F00D, 1'b1, cyc);

    // randomised mix
    for (int i = 0; i < 10; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_instr($urandom, kind != 0, kind == 2, (kind != 2) && ($urandom_range(0, 1) == 1),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom, 1'b0, cyc);
    end
    check_eq("instret_total", o_instret, 64'd16);

    // reset while a load sits in MEM_WAIT
    wait_im_valid();
    i_im_req_ready = 1'b1;
    @(negedge clk);
    i_im_req_ready = 1'b0;
    i_im_rsp_valid = 1'b1;
    i_im_rsp_data  = 32'h0000_2183;
    @(negedge clk);
    i_im_rsp_valid = 1'b0;
    i_cu_dm_access = 1'b1;
    i_cu_dm_write  = 1'b0;
    i_cu_rf_wvalid = 1'b1;
    @(negedge clk);
    i_dm_req_ready = 1'b1;
    @(negedge clk);
    i_dm_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_instr", 64'(o_instr), 64'h13);
    check_eq("mrst_instret", o_instret, 64'd0);
    check_eq("mrst_pc_update", 64'(o_pc_update), 64'd0);
    check_eq("mrst_rdata", 64'(o_dm_rdata), 64'd0);
    check_eq("mrst_dm_valid", 64'(o_dm_req_valid), 64'd0);
    rst = 1'b0;
    pc = '0;
    exp_rdata = '0;
    run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 1, 0, 0, 32'h0, 1'b0, cyc);
    check_eq("instret_after_rst", o_instret, 64'd1);

`ifdef CORE_SEQ_TIMEOUT_EN
    // fetch never accepted: trap after 8 cycles in the phase
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_im_req_ready = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("trap_not_yet", 64'(o_trap), 64'd0);
    @(negedge clk);
    check_eq("trap_set", 64'(o_trap), 64'd1);
    check_eq("trap_im_valid", 64'(o_im_req_valid), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("trap_sticky", 64'(o_trap), 64'd1);
    check_eq("trap_im_valid_low", 64'(o_im_req_valid), 64'd0);
    check_eq("trap_dm_valid_low", 64'(o_dm_req_valid), 64'd0);
`endif

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
